// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM decimator: 2-flop sync, ORDER-stage CIC decimating by DECIM, clamped to OUT_WIDTH.
// Latency: pcm_out/pcm_valid register ORDER+1 clk0 cycles after the decimation tick.
// No backpressure: pcm_valid is a one-cycle strobe and the consumer must accept every sample.
module pdm_cic_decimator #(
    parameter int DECIM     = 128,
    parameter int ORDER     = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk0,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 pdm_in,
    output logic [OUT_WIDTH-1:0] pcm_out,
    output logic                 pcm_valid,
    output logic                 pcm_sat
);

    localparam int K = $clog2(DECIM);
    localparam int W = 2 + ORDER * K;
    localparam int S = ORDER * K - (OUT_WIDTH - 1);

    localparam logic signed [W-1:0] PCM_MAX = {{(W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [W-1:0] PCM_MIN = {{(W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [2:0]          WARM_N  = 3'(ORDER);

    logic [1:0]            sync_q;
    logic signed [W-1:0]   x_val;
    logic signed [W-1:0]   integ [ORDER];
    logic [K-1:0]          dec_cnt;
    logic                  tick;
    logic signed [W-1:0]   comb [ORDER+1];
    logic signed [W-1:0]   dly [ORDER];
    logic [ORDER:0]        stg_vld;
    logic signed [W-1:0]   r_val;
    logic [OUT_WIDTH-1:0]  pcm_nxt;
    logic                  sat_nxt;
    logic [2:0]            warm_cnt;

    assign x_val = sync_q[1] ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    assign tick  = en && (dec_cnt == K'(DECIM - 1));

    // Integrators wrap modulo 2^W; the comb differences recover the exact result.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            dec_cnt <= '0;
            for (int k = 0; k < ORDER; k++) integ[k] <= '0;
        end else if (en) begin
            sync_q   <= {sync_q[0], pdm_in};
            dec_cnt  <= dec_cnt + 1'b1;
            integ[0] <= integ[0] + x_val;
            for (int k = 1; k < ORDER; k++) integ[k] <= integ[k] + integ[k-1];
        end
    end

    // Comb pipeline is driven by stg_vld alone, so it drains even while en is low.
    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            stg_vld <= '0;
            for (int k = 0; k <= ORDER; k++) comb[k] <= '0;
            for (int k = 0; k < ORDER; k++) dly[k] <= '0;
        end else begin
            stg_vld <= {stg_vld[ORDER-1:0], tick};
            if (tick) comb[0] <= integ[ORDER-1];
            for (int k = 1; k <= ORDER; k++) begin
                if (stg_vld[k-1]) begin
                    comb[k]  <= comb[k-1] - dly[k-1];
                    dly[k-1] <= comb[k-1];
                end
            end
        end
    end

    assign r_val = comb[ORDER] >>> S;

    always_comb begin
        pcm_nxt = r_val[OUT_WIDTH-1:0];
        sat_nxt = 1'b0;
        if (r_val > PCM_MAX) begin
            pcm_nxt = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            sat_nxt = 1'b1;
        end else if (r_val < PCM_MIN) begin
            pcm_nxt = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            sat_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk0 or negedge reset) begin
        if (!reset) begin
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            pcm_sat   <= 1'b0;
            warm_cnt  <= '0;
        end else begin
            pcm_valid <= 1'b0;
            if (stg_vld[ORDER]) begin
                pcm_out <= pcm_nxt;
                pcm_sat <= sat_nxt;
                if (warm_cnt == WARM_N) pcm_valid <= 1'b1;
                else                    warm_cnt  <= warm_cnt + 1'b1;
            end
        end
    end

endmodule
